// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: full 32-bit frames and repeat codes with a 38 kHz carrier
// on ir_out, and an active-low envelope on ir_rx_loop for loopback into a receiver.
module nec_ir_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int CARRIER_HZ   = 38_000,
  parameter int CARRIER_EN   = 1,
  parameter int T_LEAD_MARK  = 9000,
  parameter int T_LEAD_SPACE = 4500,
  parameter int T_BIT_MARK   = 560,
  parameter int T_ZERO_SPACE = 560,
  parameter int T_ONE_SPACE  = 1690,
  parameter int T_STOP_MARK  = 560,
  parameter int T_REP_SPACE  = 2250
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_start,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ir_out,
  output logic       ir_rx_loop
);

  localparam int US_DIV = CLK_FREQ / 1_000_000;
  localparam int PW     = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int P      = CLK_FREQ / CARRIER_HZ;
  localparam int P_HI   = P / 3;
  localparam int CW     = $clog2(P + 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_SPACE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [13:0]     dur_q, dur_d, dur_t;
  logic [5:0]      bit_q, bit_d;
  logic [31:0]     shreg_q, shreg_d;
  logic            rep_q, rep_d;
  logic [CW-1:0]   car_q, car_d;
  logic            busy_q, busy_d, done_q, done_d, ir_q, ir_d, loop_q, loop_d;
  logic            us_tick, st_end, env_d;

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign ir_out     = ir_q;
  assign ir_rx_loop = loop_q;

  // State register (with the datapath it sequences)
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      dur_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      rep_q   <= 1'b0;
      car_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ir_q    <= 1'b0;
      loop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dur_q   <= dur_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rep_q   <= rep_d;
      car_q   <= car_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ir_q    <= ir_d;
      loop_q  <= loop_d;
    end
  end

  always_comb begin
    dur_t = 14'd1;
    case (state_q)
      LEAD_MARK:  dur_t = 14'(T_LEAD_MARK);
      LEAD_SPACE: dur_t = 14'(T_LEAD_SPACE);
      BIT_MARK:   dur_t = 14'(T_BIT_MARK);
      BIT_SPACE:  dur_t = shreg_q[0] ? 14'(T_ONE_SPACE) : 14'(T_ZERO_SPACE);
      STOP_MARK:  dur_t = 14'(T_STOP_MARK);
      REP_SPACE:  dur_t = 14'(T_REP_SPACE);
      default:    dur_t = 14'd1;
    endcase
  end

  assign us_tick = (pre_q == PW'(US_DIV - 1));
  assign st_end  = us_tick && (dur_q == dur_t - 14'd1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pre_d   = us_tick ? '0 : pre_q + PW'(1);
    dur_d   = st_end ? '0 : (us_tick ? dur_q + 14'd1 : dur_q);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        dur_d = '0;
        if (tx_start || tx_repeat) begin
          state_d = LEAD_MARK;
          pre_d   = '0;
          bit_d   = '0;
          rep_d   = !tx_start;
          if (tx_start) shreg_d = {~tx_data, tx_data, ~tx_addr, tx_addr};
        end
      end
      LEAD_MARK:  if (st_end) state_d = rep_q ? REP_SPACE : LEAD_SPACE;
      LEAD_SPACE: if (st_end) state_d = BIT_MARK;
      BIT_MARK:   if (st_end) state_d = BIT_SPACE;
      BIT_SPACE: if (st_end) begin
        shreg_d = shreg_q >> 1;
        bit_d   = bit_q + 6'd1;
        state_d = (bit_q == 6'd31) ? STOP_MARK : BIT_MARK;
      end
      REP_SPACE:  if (st_end) state_d = STOP_MARK;
      STOP_MARK: if (st_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    env_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);
    if (env_d && loop_q)              car_d = '0;
    else if (car_q == CW'(P - 1))     car_d = '0;
    else                              car_d = car_q + CW'(1);
    ir_d   = env_d && ((CARRIER_EN == 0) || (car_d < CW'(P_HI)));
    loop_d = !env_d;
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx with durations scaled by 1/10 and 2 clocks per us,
// carrier period 1315 cycles (438 high).
module tb_nec_ir_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0, tx_repeat = 1'b0;
  logic [7:0] tx_addr = 8'h00, tx_data = 8'h00;
  logic       tx_busy, tx_done, ir_out, ir_rx_loop;

  int n_chk = 0, n_err = 0;

  // Expected durations in clock cycles (scaled us * 2)
  localparam int C_LEAD = 1800, C_LSP = 900, C_MARK = 112, C_ZERO = 112;
  localparam int C_ONE = 338, C_STOP = 112, C_REP = 450;
  localparam int C_FRAME = 13596, C_RPT = 2362;

  nec_ir_tx #(
    .CLK_FREQ(2_630_000), .CARRIER_HZ(2_000), .CARRIER_EN(1),
    .T_LEAD_MARK(900), .T_LEAD_SPACE(450), .T_BIT_MARK(56), .T_ZERO_SPACE(56),
    .T_ONE_SPACE(169), .T_STOP_MARK(56), .T_REP_SPACE(225)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_start(tx_start), .tx_repeat(tx_repeat),
    .tx_addr(tx_addr), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .ir_out(ir_out), .ir_rx_loop(ir_rx_loop)
  );

  always #5 clk = ~clk;

  // Monitor: run lengths of ir_rx_loop, carrier sanity, busy/done timestamps
  int q_lvl[$], q_len[$];
  logic lvl_prev = 1'b1, busy_prev = 1'b0;
  int run = 0, cyc = 0, t_busy = 0, t_done = 0, done_cnt = 0, sp_viol = 0, mk_viol = 0, marks = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ir_rx_loop === 1'b1 && ir_out !== 1'b0) sp_viol <= sp_viol + 1;
    if (ir_rx_loop === 1'b0 && lvl_prev === 1'b1) begin
      marks <= marks + 1;
      if (ir_out !== 1'b1) mk_viol <= mk_viol + 1;
    end
    if (ir_rx_loop !== lvl_prev) begin
      q_lvl.push_back(int'(lvl_prev));
      q_len.push_back(run);
      run <= 1;
      lvl_prev <= ir_rx_loop;
    end else run <= run + 1;
    if (tx_busy && !busy_prev) t_busy <= cyc;
    busy_prev <= tx_busy;
    if (tx_done) begin
      t_done <= cyc;
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic pulse(input logic s, input logic r, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tx_start = s; tx_repeat = r; tx_addr = a; tx_data = d;
    @(negedge clk);
    tx_start = 1'b0; tx_repeat = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk += 4;
    if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", tx_done); end
    if (ir_out !== 1'b0) begin n_err++; $display("FAIL reset_ir_out got %b want 0", ir_out); end
    if (ir_rx_loop !== 1'b1) begin n_err++; $display("FAIL reset_loop got %b want 1", ir_rx_loop); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    int d0;
    pulse(1'b1, 1'b0, 8'h12, 8'h34);
    n_chk++;
    if (tx_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_start got %b want 1", tx_busy); end
    repeat (4000) @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk += 3;
    if (tx_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", tx_busy); end
    if (ir_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_ir_out got %b want 0", ir_out); end
    if (ir_rx_loop !== 1'b1) begin n_err++; $display("FAIL mid_rst_loop got %b want 1", ir_rx_loop); end
    repeat (300) @(negedge clk);
    n_chk += 2;
    if (done_cnt != d0) begin n_err++; $display("FAIL mid_rst_done got %0d pulses want 0", done_cnt - d0); end
    if (tx_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_idle got %b want 0", tx_busy); end
  endtask

  // Full frame addr=0x00 data=0x16, carrier shape in lead mark, ignored tx_start while busy
  task automatic test_frame_busy;
    int base, d0, sv0, mv0, mk0, hi, first_low, exp_len;
    bit ok;
    logic [31:0] w;
    w = 32'hE916FF00;
    base = q_len.size(); d0 = done_cnt; sv0 = sp_viol; mv0 = mk_viol; mk0 = marks;
    pulse(1'b1, 1'b0, 8'h00, 8'h16);
    hi = 0; first_low = -1;
    for (int c = 0; c <= 1315; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 1315) begin
        if (ir_out === 1'b1) hi++;
        else if (first_low < 0) first_low = c;
      end else begin
        n_chk++;
        if (ir_out !== 1'b1) begin n_err++; $display("FAIL carrier_period got ir_out=%b at 1315 want 1", ir_out); end
      end
    end
    n_chk += 2;
    if (hi != 438) begin n_err++; $display("FAIL carrier_high got %0d want 438", hi); end
    if (first_low != 438) begin n_err++; $display("FAIL carrier_fall got %0d want 438", first_low); end
    repeat (684) @(negedge clk);
    pulse(1'b1, 1'b0, 8'h00, 8'hAA);
    wait_done(d0, ok);
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL frame_done timeout"); return; end
    n_chk += 5;
    if (t_done - t_busy != C_FRAME) begin n_err++; $display("FAIL frame_len got %0d want %0d", t_done - t_busy, C_FRAME); end
    if (q_len.size() != base + 68) begin n_err++; $display("FAIL frame_runs got %0d want 68", q_len.size() - base); return; end
    if (sp_viol != sv0) begin n_err++; $display("FAIL space_ir_out got %0d bad cycles want 0", sp_viol - sv0); end
    if (mk_viol != mv0) begin n_err++; $display("FAIL mark_first_high got %0d bad marks want 0", mk_viol - mv0); end
    if (marks - mk0 != 34) begin n_err++; $display("FAIL mark_count got %0d want 34", marks - mk0); end
    n_chk += 3;
    if (q_lvl[base+1] != 0 || q_len[base+1] != C_LEAD) begin n_err++; $display("FAIL lead_mark got %0d want %0d", q_len[base+1], C_LEAD); end
    if (q_len[base+2] != C_LSP) begin n_err++; $display("FAIL lead_space got %0d want %0d", q_len[base+2], C_LSP); end
    if (q_len[base+67] != C_STOP) begin n_err++; $display("FAIL stop_mark got %0d want %0d", q_len[base+67], C_STOP); end
    for (int i = 0; i < 32; i++) begin
      exp_len = w[i] ? C_ONE : C_ZERO;
      n_chk += 2;
      if (q_len[base+3+2*i] != C_MARK) begin n_err++; $display("FAIL bit%0d_mark got %0d want %0d", i, q_len[base+3+2*i], C_MARK); end
      if (q_len[base+4+2*i] != exp_len) begin n_err++; $display("FAIL bit%0d_space got %0d want %0d", i, q_len[base+4+2*i], exp_len); end
    end
  endtask

  // tx_start+tx_repeat together in the cycle right after tx_done: a full frame must follow
  task automatic test_back_to_back;
    int base, d0;
    bit ok;
    logic [31:0] w, got;
    w = 32'hBA45FF00;
    base = q_len.size(); d0 = done_cnt;
    pulse(1'b1, 1'b1, 8'h00, 8'h45);
    n_chk++;
    if (tx_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b want 1", tx_busy); end
    wait_done(d0, ok);
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL b2b_done timeout"); return; end
    n_chk += 2;
    if (t_done - t_busy != C_FRAME) begin n_err++; $display("FAIL b2b_len got %0d want %0d", t_done - t_busy, C_FRAME); end
    if (q_len.size() != base + 68) begin n_err++; $display("FAIL b2b_runs got %0d want 68", q_len.size() - base); return; end
    got = '0;
    for (int i = 0; i < 32; i++) got[i] = (q_len[base+4+2*i] == C_ONE);
    n_chk++;
    if (got !== w) begin n_err++; $display("FAIL b2b_word got %h want %h", got, w); end
  endtask

  task automatic test_repeat;
    int base, d0;
    bit ok;
    repeat (20) @(negedge clk);
    base = q_len.size(); d0 = done_cnt;
    pulse(1'b0, 1'b1, 8'hFF, 8'hFF);
    wait_done(d0, ok);
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL rpt_done timeout"); return; end
    n_chk += 2;
    if (t_done - t_busy != C_RPT) begin n_err++; $display("FAIL rpt_len got %0d want %0d", t_done - t_busy, C_RPT); end
    if (q_len.size() != base + 4) begin n_err++; $display("FAIL rpt_runs got %0d want 4", q_len.size() - base); return; end
    n_chk += 3;
    if (q_len[base+1] != C_LEAD) begin n_err++; $display("FAIL rpt_lead got %0d want %0d", q_len[base+1], C_LEAD); end
    if (q_len[base+2] != C_REP) begin n_err++; $display("FAIL rpt_space got %0d want %0d", q_len[base+2], C_REP); end
    if (q_len[base+3] != C_STOP) begin n_err++; $display("FAIL rpt_stop got %0d want %0d", q_len[base+3], C_STOP); end
    @(negedge clk);
    n_chk++;
    if (tx_done !== 1'b0) begin n_err++; $display("FAIL rpt_done_width got %b want 0", tx_done); end
  endtask

  initial begin
    test_reset;
    test_reset_mid_frame;
    test_frame_busy;
    test_back_to_back;
    test_repeat;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
